tl_status_uart_tx: RTL and testbench
====================================

Name: tl_status_uart_tx

Overview:
Serial status reporter for the traffic-light controller. It watches the timer controller's phase and seconds-count outputs and sends an ASCII status frame over a UART TX line (8N1, LSB first) whenever the status changes. This gives a host PC the outbound view of the controller state that the buttons feed in. It sits beside the display controller, in the 25 MHz domain, and drives one Pmod/USB-UART pin.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200 baud).
HEARTBEAT_CYCLES, 25000000, idle period before a forced resend; used only with the optional feature.

Ports:
clk        input   1  25 MHz system clock (clk25 domain)
rst_n      input   1  asynchronous, active-low reset
en         input   1  reporting enable; level-sensitive
phase      input   3  current controller phase, same clock domain
s_num      input   4  current seconds count, same clock domain
tx         output  1  UART serial out, idles high
busy       output  1  high while a frame is being shifted
frame_done output  1  one-cycle pulse at the end of the last stop bit of a frame

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values:
  - tx=1, busy=0, frame_done=0.
  - Snapshot register = 0; snap_valid=0; pending=0; FSM=IDLE.
- Frame format: 6 bytes, in this order:
  - 'P' (0x50)
  - '0'+phase (0x30–0x37)
  - 'S' (0x53)
  - hex digit of s_num: 0–9 → 0x30–0x39, A–F → 0x41–0x46 (uppercase)
  - CR (0x0D)
  - LF (0x0A)
- Byte format and timing:
  - Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - No idle gap between bytes: the next start bit follows the stop bit directly.
  - One frame = 60*CLKS_PER_BIT cycles.
- Trigger:
  - Condition: en=1 && FSM=IDLE && (!snap_valid || {phase,s_num} != snapshot || pending).
  - On trigger, {phase,s_num} is captured into the snapshot and snap_valid is set.
  - The frame is built only from the snapshot. Input changes during a frame never corrupt it.
- Latency: tx drops to the start bit and busy rises in the cycle after the trigger cycle.
- FSM states: IDLE → START → DATA (8 bits) → STOP. Then either back to START for the next byte, or, after byte 5, to DONE (1 cycle: frame_done=1, busy=0) → IDLE.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Bit index runs 0..7.
  - Byte index runs 0..5 and wraps to 0 at frame end.
- Change during a frame: if {phase,s_num} differs from the snapshot in any busy cycle, pending is set.
  - At IDLE, a new frame starts with the latest values; pending is cleared on that trigger.
  - Multiple changes during one frame yield exactly one follow-up frame.
  - If the inputs return to the snapshot value, pending stays set and a duplicate frame is sent. This is accepted.
- en deasserted mid-frame: the current frame completes. No new frame is triggered while en=0. pending is still recorded.
- en rising with unchanged status:
  - If snap_valid=1 and nothing changed, no frame is sent.
  - The first enable after reset always sends one frame.
- rst_n asserted mid-frame: tx returns high immediately (asynchronously) and the frame is abandoned. After release, the first frame is resent per the trigger rule.
- busy is high from the start bit of byte 0 through the stop bit of byte 5 inclusive.

Optional Feature:
- Macro: TL_UART_HEARTBEAT_EN.
- Defined:
  - An idle counter increments while FSM=IDLE and en=1.
  - It resets on any trigger and whenever en=0.
  - On reaching HEARTBEAT_CYCLES-1, it forces a trigger that resends the current values even if unchanged.
- Undefined: no counter is instantiated, and frames are sent only on change, first enable, or pending.

Decomposition:
- Shared package tl_pkg holds:
  - ASCII constants: CH_P, CH_S, CH_CR, CH_LF, CH_0, CH_A.
  - Default CLKS_PER_BIT_25M=217.
  - FSM state encoding typedef tl_uart_state_t.
  - Function hex2ascii(4b) → 8b.
- One natural sub-module: uart_tx_byte, a byte serializer with start/done handshake and the baud counter.
  - The top (frame sequencer, change detector, pending, heartbeat) drives it byte by byte.

Test Plan:
- Reset, en=1, phase=2, s_num=9 → tx bytes 0x50,0x32,0x53,0x39,0x0D,0x0A. Start bit at cycle T+1. frame_done at T+13020±1. busy high throughout.
- phase=5, s_num=0xB → digit byte 0x42 ('B'). Every bit width is measured as exactly 217 cycles.
- Frame in flight with phase 1→3 then 3→4 at byte 2 → current frame still reports '1'. Exactly one follow-up frame reports '4'. No third frame.
- en=0 at byte 3 → current frame completes. Change inputs, no frame sent. Set en=1 → one frame with new values.
- rst_n low at byte 1 → tx=1 the same cycle, busy=0. Release with same inputs → full frame resent from byte 0.
- TL_UART_HEARTBEAT_EN, HEARTBEAT_CYCLES=1000, static inputs → identical frames start 1000 cycles after each frame_done. Without the macro → no resend.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared constants, state encodings and ASCII helper for the traffic-light status UART reporter.
package tl_pkg;

    localparam int CLKS_PER_BIT_25M = 217;

    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_A  = 8'h41;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tl_uart_state_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DONE
    } tl_frame_state_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return CH_0 + {4'd0, nib};
        end else begin
            return CH_A + {4'd0, nib} - 8'd10;
        end
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. A start request in the last stop-bit cycle chains
// the next byte with no idle gap.
module uart_tx_byte
    import tl_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_25M
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    tl_uart_state_t state, state_nxt;
    logic [CW-1:0]  baud, baud_nxt;
    logic [2:0]     bit_idx, bit_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic           tx_nxt;
    logic           bit_end;

    assign bit_end = (baud == BAUD_MAX);
    assign done    = (state == ST_STOP) && bit_end;

    // tx is registered so reset forces the line high without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud + 1'b1;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        tx_nxt    = tx;
        unique case (state)
            ST_IDLE: begin
                baud_nxt = '0;
                if (start) begin
                    state_nxt = ST_START;
                    shreg_nxt = data;
                    tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = '0;
                    tx_nxt    = shreg[0];
                    shreg_nxt = {1'b0, shreg[7:1]};
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        tx_nxt    = shreg[0];
                        shreg_nxt = {1'b0, shreg[7:1]};
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (start) begin
                        state_nxt = ST_START;
                        shreg_nxt = data;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/tl_status_uart_tx.sv
// Sends "P<phase>S<hex>\r\n" over UART whenever the controller status changes.
// Define TL_UART_HEARTBEAT_EN to also resend periodically after HEARTBEAT_CYCLES idle cycles.
module tl_status_uart_tx
    import tl_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_25M
`ifdef TL_UART_HEARTBEAT_EN
    , parameter int HEARTBEAT_CYCLES = 25000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] phase,
    input  logic [3:0] s_num,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    tl_frame_state_t fstate, fstate_nxt;
    logic [6:0] status, snapshot;
    logic       snap_valid, pending;
    logic [2:0] byte_idx;
    logic       trigger, force_send;
    logic       byte_start, byte_done;
    logic [7:0] byte_data, next_byte;

    assign status     = {phase, s_num};
    assign busy       = (fstate == FR_SEND);
    assign frame_done = (fstate == FR_DONE);

`ifdef TL_UART_HEARTBEAT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (trigger || !en || fstate != FR_IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign force_send = en && (fstate == FR_IDLE) && (idle_cnt == 32'(HEARTBEAT_CYCLES - 1));
`else
    assign force_send = 1'b0;
`endif

    assign trigger = en && (fstate == FR_IDLE) &&
                     (!snap_valid || status != snapshot || pending || force_send);

    // Byte following the one currently on the wire; always built from the snapshot.
    always_comb begin
        next_byte = CH_P;
        unique case (byte_idx)
            3'd0:    next_byte = CH_0 + {5'd0, snapshot[6:4]};
            3'd1:    next_byte = CH_S;
            3'd2:    next_byte = hex2ascii(snapshot[3:0]);
            3'd3:    next_byte = CH_CR;
            3'd4:    next_byte = CH_LF;
            default: next_byte = CH_P;
        endcase
    end

    assign byte_data = (fstate == FR_IDLE) ? CH_P : next_byte;

    always_comb begin
        fstate_nxt = fstate;
        byte_start = 1'b0;
        unique case (fstate)
            FR_IDLE: begin
                if (trigger) begin
                    fstate_nxt = FR_SEND;
                    byte_start = 1'b1;
                end
            end
            FR_SEND: begin
                if (byte_done) begin
                    if (byte_idx == 3'd5) begin
                        fstate_nxt = FR_DONE;
                    end else begin
                        byte_start = 1'b1;
                    end
                end
            end
            FR_DONE: fstate_nxt = FR_IDLE;
            default: fstate_nxt = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate <= FR_IDLE;
        end else begin
            fstate <= fstate_nxt;
        end
    end

    // Pending collects any status change seen mid-frame so exactly one follow-up frame goes out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot   <= '0;
            snap_valid <= 1'b0;
            pending    <= 1'b0;
            byte_idx   <= '0;
        end else if (trigger) begin
            snapshot   <= status;
            snap_valid <= 1'b1;
            pending    <= 1'b0;
            byte_idx   <= '0;
        end else if (fstate == FR_SEND) begin
            if (status != snapshot) begin
                pending <= 1'b1;
            end
            if (byte_done) begin
                byte_idx <= (byte_idx == 3'd5) ? 3'd0 : byte_idx + 3'd1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst_n(rst_n),
        .start(byte_start),
        .data (byte_data),
        .tx   (tx),
        .done (byte_done)
    );

endmodule

// File: tb/tb_tl_status_uart_tx.sv
// Scoreboard bench for tl_status_uart_tx: expected bytes are queued as stimulus is applied
// and matched against bytes decoded from the tx line.
module tb_tl_status_uart_tx;

    localparam int CPB   = 40;
    localparam int FRAME = 60 * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [2:0] phase = 3'd0;
    logic [3:0] s_num = 4'd0;
    logic       tx, busy, frame_done;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int frames_seen = 0;
    int rst_events  = 0;
    int frame_start = 0;
    int expect_start = -1;
    logic in_frame  = 1'b0;
    logic prev_tx   = 1'b1;
    logic [7:0] sb_q[$];

    tl_status_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase     (phase),
        .s_num     (s_num),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexChar(input logic [3:0] v);
        if (v < 4'd10) return 8'h30 + {4'd0, v};
        return 8'h37 + {4'd0, v};
    endfunction

    task automatic pushFrame(input logic [2:0] ph, input logic [3:0] sn);
        sb_q.push_back(8'h50);
        sb_q.push_back(8'h30 + {5'd0, ph});
        sb_q.push_back(8'h53);
        sb_q.push_back(hexChar(sn));
        sb_q.push_back(8'h0D);
        sb_q.push_back(8'h0A);
    endtask

    task automatic applyStimulus(input logic en_v, input logic [2:0] ph, input logic [3:0] sn);
        @(negedge clk);
        en    = en_v;
        phase = ph;
        s_num = sn;
    endtask

    task automatic expectFrameNow(input logic [2:0] ph, input logic [3:0] sn);
        pushFrame(ph, sn);
        expect_start = cyc + 1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frames_reached", frames_seen, target);
    endtask

    initial forever begin
        @(negedge rst_n);
        rst_events++;
    end

    // Frame-level monitor: start latency, bit-edge alignment, frame length, busy at done.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && prev_tx && !tx) begin
                in_frame    = 1'b1;
                frame_start = cyc;
                if (expect_start >= 0) begin
                    checkOutput("start_latency", cyc, expect_start);
                    expect_start = -1;
                end
            end else if (in_frame && tx !== prev_tx) begin
                checkOutput("bit_edge_align", (cyc - frame_start) % CPB, 0);
            end
            if (frame_done) begin
                checkOutput("done_inside_frame", {31'd0, in_frame}, 1);
                if (in_frame) checkOutput("frame_len", cyc - frame_start, FRAME);
                checkOutput("busy_at_done", busy, 0);
                in_frame = 1'b0;
                frames_seen++;
            end
        end
        prev_tx = tx;
    end

    // Byte decoder: samples mid-bit, discards any byte interrupted by reset.
    initial begin : rx_decoder
        logic [7:0] b;
        logic [7:0] exp_b;
        int ev;
        forever begin
            @(negedge clk);
            if (rst_n && tx == 1'b0) begin
                ev = rst_events;
                repeat (CPB / 2) @(negedge clk);
                if (ev == rst_events) begin
                    checkOutput("start_bit", tx, 0);
                    checkOutput("busy_mid_frame", busy, 1);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (ev == rst_events && rst_n) begin
                    checkOutput("stop_bit", tx, 1);
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = sb_q.pop_front();
                        checkOutput("rx_byte", b, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(20);
        checkOutput("idle_without_en_tx", tx, 1);
        checkOutput("idle_without_en_frames", frames_seen, 0);

        // First enable after reset: phase 2, seconds 9.
        applyStimulus(1'b1, 3'd2, 4'd9);
        expectFrameNow(3'd2, 4'd9);
        waitFrames(1, FRAME + 50);

        // Hex digit above 9.
        applyStimulus(1'b1, 3'd5, 4'hB);
        expectFrameNow(3'd5, 4'hB);
        waitFrames(2, FRAME + 50);
        checkOutput("sb_empty_after_hex", sb_q.size(), 0);

        // Two changes mid-frame give exactly one follow-up frame with the latest value.
        applyStimulus(1'b1, 3'd1, 4'd3);
        expectFrameNow(3'd1, 4'd3);
        waitCycles(2 * 10 * CPB + CPB);
        applyStimulus(1'b1, 3'd3, 4'd3);
        waitCycles(CPB);
        applyStimulus(1'b1, 3'd4, 4'd3);
        pushFrame(3'd4, 4'd3);
        waitFrames(4, 2 * FRAME + 100);
        waitCycles(FRAME + 200);
        checkOutput("no_third_frame", frames_seen, 4);
        checkOutput("idle_tx_after_followup", tx, 1);
        checkOutput("sb_empty_after_followup", sb_q.size(), 0);

        // en dropped mid-frame: frame completes, nothing sent while disabled.
        applyStimulus(1'b1, 3'd6, 4'd7);
        expectFrameNow(3'd6, 4'd7);
        waitCycles(3 * 10 * CPB + CPB);
        applyStimulus(1'b0, 3'd6, 4'd7);
        waitFrames(5, FRAME);
        applyStimulus(1'b0, 3'd7, 4'd2);
        waitCycles(FRAME);
        checkOutput("no_frame_while_disabled", frames_seen, 5);
        checkOutput("disabled_tx_idle", tx, 1);
        applyStimulus(1'b1, 3'd7, 4'd2);
        expectFrameNow(3'd7, 4'd2);
        waitFrames(6, FRAME + 50);

        // Re-enable with unchanged status sends nothing.
        applyStimulus(1'b0, 3'd7, 4'd2);
        waitCycles(10);
        applyStimulus(1'b1, 3'd7, 4'd2);
        waitCycles(FRAME / 2);
        checkOutput("en_rise_unchanged", frames_seen, 6);
        checkOutput("en_rise_unchanged_busy", busy, 0);

        // Reset in the start bit of byte 1: tx high at once, full frame resent afterwards.
        applyStimulus(1'b1, 3'd3, 4'hF);
        expectFrameNow(3'd3, 4'hF);
        waitCycles(10 * CPB + CPB / 2 + 3);
        checkOutput("tx_low_before_reset", tx, 0);
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", tx, 1);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_done", frame_done, 0);
        waitCycles(12 * CPB);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        expectFrameNow(3'd3, 4'hF);
        waitFrames(7, FRAME + 50);

`ifndef TL_UART_HEARTBEAT_EN
        waitCycles(FRAME + 100);
        checkOutput("no_resend_static_inputs", frames_seen, 7);
`endif
        checkOutput("sb_final_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
